// File: rtl/cpu_multicycle_ctrl.sv
// cpu_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM with shared-memory req/ack handshake
module cpu_multicycle_ctrl #(
  parameter int OPW  = 6,
  parameter int FW   = 6,
  parameter int CNTW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [OPW-1:0]  opcode,
  input  logic [FW-1:0]   funct,
  input  logic            zero,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_sel_data,
  output logic            mem_we,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_src,
  output logic            alu_src_imm,
  output logic [3:0]      alu_op,
  output logic            rf_we,
  output logic            rf_dst_rd,
  output logic            rf_src_mem,
  output logic [2:0]      state,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t cur, nxt, ret;
  logic op_r, op_lw, op_sw, op_addi, op_beq, op_bne, op_j, op_halt, legal, set_illegal, taken;
  logic [3:0] r_alu;
  always_comb begin
    op_r    = opcode == OPW'('h00);
    op_lw   = opcode == OPW'('h23);
    op_sw   = opcode == OPW'('h2B);
    op_addi = opcode == OPW'('h08);
    op_beq  = opcode == OPW'('h04);
    op_bne  = opcode == OPW'('h05);
    op_j    = opcode == OPW'('h02);
    op_halt = opcode == OPW'('h3F);
    r_alu   = funct == FW'('h20) ? 4'd0 : funct == FW'('h22) ? 4'd1 : funct == FW'('h24) ? 4'd2 :
              funct == FW'('h25) ? 4'd3 : funct == FW'('h2A) ? 4'd4 : funct == FW'('h00) ? 4'd5 :
              funct == FW'('h02) ? 4'd6 : 4'd15;
    legal   = (op_r && r_alu != 4'd15) || op_lw || op_sw || op_addi || op_beq || op_bne || op_j || op_halt;
    taken   = zero ^ op_bne;
    ret     = run ? FETCH : IDLE;
  end
  always_comb begin
    nxt          = cur;
    mem_req      = 1'b0;
    mem_sel_data = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_src_imm  = 1'b0;
    alu_op       = 4'd0;
    rf_we        = 1'b0;
    rf_dst_rd    = 1'b0;
    rf_src_mem   = 1'b0;
    set_illegal  = 1'b0;
    case (cur)
      IDLE:   nxt = ret;
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
        pc_we   = mem_ack;
        nxt     = mem_ack ? DECODE : FETCH;
      end
      DECODE: begin
        set_illegal = !legal;
        pc_we       = legal && op_j;
        pc_src      = (legal && op_j) ? 2'd2 : 2'd0;
        nxt         = (op_halt || !legal) ? HALT : op_j ? ret : EXEC;
      end
      EXEC: begin
        alu_src_imm = op_lw || op_sw || op_addi;
        alu_op      = alu_src_imm ? 4'd0 : (op_beq || op_bne) ? 4'd1 : r_alu;
        pc_we       = (op_beq || op_bne) && taken;
        pc_src      = ((op_beq || op_bne) && taken) ? 2'd1 : 2'd0;
        nxt         = (op_beq || op_bne) ? ret : (op_lw || op_sw) ? MEM : WB;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = op_sw;
        nxt          = !mem_ack ? MEM : op_sw ? ret : WB;
      end
      WB: begin
        rf_we      = 1'b1;
        rf_dst_rd  = op_r;
        rf_src_mem = op_lw;
        nxt        = ret;
      end
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cur         <= IDLE;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      cur         <= nxt;
      illegal     <= illegal | set_illegal;
      instr_count <= instr_count + CNTW'(ir_we);
    end
  end
  assign state  = cur;
  assign halted = cur == HALT;
endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// tb_cpu_multicycle_ctrl: random instruction streams vs. a transaction-level event model, plus directed corner cases
module tb_cpu_multicycle_ctrl;
  logic clock = 0, reset = 1, run = 0, zero = 0, mem_ack = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic mem_req, mem_sel_data, mem_we, ir_we, pc_we, alu_src_imm, rf_we, rf_dst_rd, rf_src_mem, halted, illegal;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic [2:0] state;
  logic [31:0] instr_count;

  cpu_multicycle_ctrl dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_sel_data(mem_sel_data), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
    .rf_we(rf_we), .rf_dst_rd(rf_dst_rd), .rf_src_mem(rf_src_mem), .state(state),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st; logic ir, pc; logic [1:0] src; logic rf, rd, sm, acc, sel, we; logic [3:0] alu; logic imm;
  } ev_t;

  ev_t exp_q[$];
  int gap_q[$], dly_q[$];
  logic [12:0] ins_q[$];
  int checks = 0, fails = 0, pend = 0;
  bit first = 1;
  logic [5:0] rtab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
  logic [5:0] itab [6] = '{6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02};

  function automatic ev_t mk(input logic [2:0] st, input logic ir, pc, input logic [1:0] src,
                             input logic rf, rd, sm, acc, sel, we, input logic [3:0] alu, input logic imm);
    return '{st, ir, pc, src, rf, rd, sm, acc, sel, we, alu, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  // Expected observable events of one instruction; fd/md are the fetch/data ack delays.
  task automatic issue(input logic [5:0] op, fn, input logic z, input int fd, md);
    int idx = -1;
    logic tk;
    ins_q.push_back({z, op, fn});
    dly_q.push_back(fd);
    exp_q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    gap_q.push_back(first ? -1 : pend + fd);
    first = 0;
    if (op == 6'h02) begin
      exp_q.push_back(mk(2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      pend = 2;
    end else if (op == 6'h04 || op == 6'h05) begin
      tk = z ^ (op == 6'h05);
      exp_q.push_back(mk(3, 0, tk, tk ? 2'd1 : 2'd0, 0, 0, 0, 0, 0, 0, 1, 0));
      pend = 3;
    end else if (op == 6'h00) begin
      for (int i = 0; i < 7; i++) if (rtab[i] == fn) idx = i;
      if (idx >= 0) begin
        exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'(idx), 0));
        exp_q.push_back(mk(5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        pend = 4;
      end
    end else if (op == 6'h08) begin
      exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      exp_q.push_back(mk(5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      pend = 4;
    end else if (op == 6'h23 || op == 6'h2B) begin
      exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      dly_q.push_back(md);
      exp_q.push_back(mk(4, 0, 0, 0, 0, 0, 0, 1, 1, op == 6'h2B, 0, 0));
      if (op == 6'h23) exp_q.push_back(mk(5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      pend = (op == 6'h23 ? 5 : 4) + md;
    end
  endtask

  task automatic issue_rand();
    int k = $urandom_range(0, 12);
    logic z = 1'($urandom);
    int fd = $urandom_range(0, 3), md = $urandom_range(0, 3);
    if (k < 7) issue(6'h00, rtab[k], z, fd, md);
    else issue(itab[k-7], 6'($urandom), z, fd, md);
  endtask

  task automatic do_reset();
    reset = 1;
    run = 0;
    @(posedge clock); #3;
    exp_q.delete(); gap_q.delete(); dly_q.delete(); ins_q.delete();
    first = 1;
    reset = 0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
    int n = 0;
    while (state !== s && n < lim) begin
      @(posedge clock); #3;
      n++;
    end
    chk(nm, 32'(state), 32'(s));
  endtask

  // Memory model: acks each request after its queued delay, loads the IR after a fetch ack.
  bit active = 0, acked = 0, afetch = 0;
  int w = 0;
  initial forever begin
    @(posedge clock); #1;
    if (reset) begin
      active = 0; acked = 0; mem_ack = 0;
    end else begin
      if (acked && afetch && ins_q.size() > 0) {zero, opcode, funct} = ins_q.pop_front();
      if (acked) active = 0;
      acked = 0;
      if (mem_req && !active) begin
        active = 1;
        w = dly_q.size() > 0 ? dly_q.pop_front() : 100000;
      end
      if (active) begin
        if (w == 0) begin
          mem_ack = 1; acked = 1; afetch = !mem_sel_data;
        end else begin
          mem_ack = 0; w--;
        end
      end else mem_ack = 1'($urandom);
    end
  end

  // Monitor: pops the expected event whenever the DUT strobes or sits in EXEC.
  ev_t got, e;
  int cyc = 0, g;
  bit prq = 0;
  initial forever begin
    @(negedge clock);
    if (reset) begin
      cyc = 0; prq = 0;
      continue;
    end
    cyc++;
    if (prq) begin
      checks++;
      if (!mem_req) begin fails++; $display("FAIL req_drop: mem_req=0 required 1 before ack"); end
    end
    prq = mem_req && !mem_ack;
    if (mem_we) begin
      checks++;
      if (!mem_req) begin fails++; $display("FAIL we_noreq: mem_we=1 with mem_req=0"); end
    end
    if (state == 3'd3 || ir_we || pc_we || rf_we || (mem_req && mem_ack)) begin
      got = '{state, ir_we, pc_we, pc_src, rf_we, rf_dst_rd, rf_src_mem, mem_req && mem_ack,
              mem_sel_data, mem_we, alu_op, alu_src_imm};
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL event: got %h required none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin fails++; $display("FAIL event: got %h required %h", got, e); end
      end
    end
    if (ir_we) begin
      if (gap_q.size() > 0) begin
        g = gap_q.pop_front();
        if (g >= 0) begin
          checks++;
          if (cyc != g) begin fails++; $display("FAIL latency: got %0d cycles required %0d", cyc, g); end
        end
      end
      cyc = 0;
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #3;
    chk("reset_state", 32'(state), 0);
    chk("reset_strobes", {mem_req, mem_we, ir_we, pc_we, rf_we, halted, illegal}, 0);
    chk("reset_selects", {mem_sel_data, pc_src, alu_src_imm, alu_op, rf_dst_rd, rf_src_mem}, 0);
    chk("reset_count", instr_count, 0);
    reset = 0;
    for (int i = 0; i < 150; i++) issue_rand();
    issue(6'h3F, 6'h00, 0, 1, 0);
    run = 1;
    wait_state(3'd6, 20000, "rand_halt");
    chk("rand_events_left", exp_q.size(), 0);
    chk("rand_count", instr_count, 151);
    chk("rand_illegal", illegal, 0);
    chk("rand_halted", halted, 1);
    begin
      int reqs = 0;
      repeat (10) begin @(posedge clock); #3; reqs += mem_req; end
      chk("halt_no_req", reqs, 0);
      chk("halt_stays", 32'(state), 6);
    end

    do_reset();
    issue(6'h3E, 6'h00, 0, 0, 0);
    run = 1;
    wait_state(3'd6, 50, "illegal_op_halt");
    chk("illegal_op_flag", illegal, 1);
    do_reset();
    chk("illegal_cleared", illegal, 0);
    issue(6'h00, 6'h3F, 0, 2, 0);
    run = 1;
    wait_state(3'd6, 50, "illegal_fn_halt");
    chk("illegal_fn_flag", illegal, 1);
    chk("illegal_events_left", exp_q.size(), 0);

    do_reset();
    issue(6'h2B, 6'h11, 0, 1, 2);
    run = 1;
    wait_state(3'd3, 50, "sw_exec");
    run = 0;
    wait_state(3'd0, 50, "sw_to_idle");
    chk("sw_events_left", exp_q.size(), 0);
    repeat (3) begin @(posedge clock); #3; end
    chk("idle_held", {29'd0, state}, 0);
    first = 1;
    issue(6'h02, 6'h00, 0, 20, 0);
    run = 1;
    @(posedge clock); #3;
    chk("idle_to_fetch", 32'(state), 1);
    repeat (5) begin @(posedge clock); #3; end
    chk("fetch_pending_req", mem_req, 1);
    chk("fetch_count_before", instr_count, 1);
    reset = 1;
    @(posedge clock); #3;
    chk("midfetch_reset_state", 32'(state), 0);
    chk("midfetch_reset_req", mem_req, 0);
    chk("midfetch_reset_count", instr_count, 0);
    reset = 0;
    exp_q.delete(); gap_q.delete(); dly_q.delete(); ins_q.delete();
    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
